// File: rtl/pipeline_scoreboard_pkg.sv
// Shared constants for the pipeline scoreboard: register-index widths,
// forward-select encoding and the HI/LO counter indices.
package pipeline_scoreboard_pkg;

  // GPR index width and count; GPR 0 is hard-wired and never tracked.
  localparam int unsigned GPR_W   = 5;
  localparam int unsigned NUM_GPR = 32;

  // Forward-select encoding: 0 reads the register file, k selects stage k.
  localparam int unsigned SEL_REGFILE = 0;

  // HI/LO special-register indices into the two-entry HI/LO vectors.
  localparam int unsigned HILO_HI  = 0;
  localparam int unsigned HILO_LO  = 1;
  localparam int unsigned NUM_HILO = 2;

  // Width of one forward-select field for a given number of stages.
  function automatic int unsigned sel_width(input int unsigned num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_sb_counter.sv
// sb_counter: one per-register latency counter. Counts down to zero each
// cycle; a load keeps the larger of the decremented value and the new
// latency so a short-latency writer never hides a longer one in flight.
module sb_counter #(
  parameter int unsigned LAT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] cnt_o
);

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] dec;

  // Next count: clear wins, then max-load, otherwise saturating decrement.
  always_comb begin
    dec   = (cnt_q != '0) ? (cnt_q - LAT_W'(1)) : '0;
    cnt_d = dec;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = (dec > load_val_i) ? dec : load_val_i;
    end
  end

  // Counter state, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: per-GPR latency scoreboard for an in-order pipeline.
// Stalls decode while a source register still has a result in flight, picks
// the youngest forwarding stage for each source, and counts stall cycles.
// Optional HI/LO tracking is enabled by defining SCOREBOARD_HILO_EN.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LAT_W      = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        flush,
  input  logic                                        issue_valid,
  input  logic [4:0]                                  issue_dest,
  input  logic [LAT_W-1:0]                            issue_latency,
  input  logic [NUM_SRC*5-1:0]                        src_reg,
  input  logic [NUM_STAGES-1:0]                       stage_wr,
  input  logic [NUM_STAGES*5-1:0]                     stage_dest,
`ifdef SCOREBOARD_HILO_EN
  input  logic [1:0]                                  issue_hilo,
  input  logic [1:0]                                  src_hilo,
  input  logic [NUM_STAGES*2-1:0]                     stage_hilo_wr,
  output logic [2*$clog2(NUM_STAGES+1)-1:0]           hilo_fwd_sel,
`endif
  output logic                                        stall,
  output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]     src_fwd_sel,
  output logic [31:0]                                 stall_count
);

  localparam int unsigned SEL_W = sel_width(NUM_STAGES);

  logic [LAT_W-1:0]         cnt [NUM_GPR];
  logic                     stall_raw;
  logic                     issue_acc;
  logic [GPR_W-1:0]         stall_idx;
  logic [GPR_W-1:0]         fwd_idx;
  logic [SEL_W-1:0]         fwd_one;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [31:0]              stall_count_q, stall_count_d;

  // A stalled or flushed issue is dropped; counters then only decrement.
  assign issue_acc = issue_valid & ~stall_raw & ~flush;

  // GPR 0 has no counter and reads as idle.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_GPR; r++) begin : g_gpr
    sb_counter #(
      .LAT_W (LAT_W)
    ) u_cnt (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .clr_i      (flush),
      .load_i     (issue_acc && (issue_dest == GPR_W'(r))),
      .load_val_i (issue_latency),
      .cnt_o      (cnt[r])
    );
  end

`ifdef SCOREBOARD_HILO_EN
  logic [LAT_W-1:0] hilo_cnt [NUM_HILO];
  logic [SEL_W-1:0] hilo_one;
  logic [2*SEL_W-1:0] hilo_sel;

  for (genvar h = 0; h < NUM_HILO; h++) begin : g_hilo
    sb_counter #(
      .LAT_W (LAT_W)
    ) u_cnt (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .clr_i      (flush),
      .load_i     (issue_acc && issue_hilo[h]),
      .load_val_i (issue_latency),
      .cnt_o      (hilo_cnt[h])
    );
  end

  // HI/LO forwarding: youngest stage writing the requested special register.
  always_comb begin
    hilo_sel = '0;
    hilo_one = '0;
    for (int unsigned h = 0; h < NUM_HILO; h++) begin
      hilo_one = SEL_W'(SEL_REGFILE);
      // Walk oldest to youngest so the youngest match is the one that sticks.
      for (int unsigned k = NUM_STAGES; k > 0; k--) begin
        if (src_hilo[h] && stage_hilo_wr[(k-1)*NUM_HILO + h]) begin
          hilo_one = SEL_W'(k);
        end
      end
      hilo_sel[h*SEL_W +: SEL_W] = hilo_one;
    end
  end

  assign hilo_fwd_sel = reset_n ? hilo_sel : '0;
`endif

  // Hazard detect: any nonzero source with a result still in flight.
  always_comb begin
    stall_raw = 1'b0;
    stall_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      stall_idx = src_reg[i*GPR_W +: GPR_W];
      if ((stall_idx != '0) && (cnt[stall_idx] != '0)) begin
        stall_raw = 1'b1;
      end
    end
`ifdef SCOREBOARD_HILO_EN
    for (int unsigned h = 0; h < NUM_HILO; h++) begin
      if (src_hilo[h] && (hilo_cnt[h] != '0)) begin
        stall_raw = 1'b1;
      end
    end
`endif
  end

  // GPR forwarding: lowest-numbered (youngest) stage writing the source wins.
  always_comb begin
    fwd_sel = '0;
    fwd_idx = '0;
    fwd_one = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      fwd_idx = src_reg[i*GPR_W +: GPR_W];
      fwd_one = SEL_W'(SEL_REGFILE);
      for (int unsigned k = NUM_STAGES; k > 0; k--) begin
        if (stage_wr[k-1] && (fwd_idx != '0) &&
            (stage_dest[(k-1)*GPR_W +: GPR_W] == fwd_idx)) begin
          fwd_one = SEL_W'(k);
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = fwd_one;
    end
  end

  // Outputs read as idle while reset is held, regardless of stage inputs.
  assign stall       = stall_raw & reset_n;
  assign src_fwd_sel = reset_n ? fwd_sel : '0;

  // Saturating stall-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_raw && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Stall-count state, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed self-checking bench for pipeline_scoreboard (default build).
`timescale 1ns/1ps
module tb_pipeline_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic [3:0]  issue_latency;
  logic [9:0]  src_reg;
  logic [2:0]  stage_wr;
  logic [14:0] stage_dest;
  logic        stall;
  logic [3:0]  src_fwd_sel;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  pipeline_scoreboard #(
    .NUM_SRC    (2),
    .NUM_STAGES (3),
    .LAT_W      (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_dest    (issue_dest),
    .issue_latency (issue_latency),
    .src_reg       (src_reg),
    .stage_wr      (stage_wr),
    .stage_dest    (stage_dest),
    .stall         (stall),
    .src_fwd_sel   (src_fwd_sel),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; issue_valid = 0; issue_dest = 0; issue_latency = 0;
    src_reg = 0; stage_wr = 0; stage_dest = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    src_reg = {5'd0, 5'd2};
    stage_wr = 3'b001;
    stage_dest = {5'd0, 5'd0, 5'd2};
    #2;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++;
    if (src_fwd_sel !== 4'b0000) begin
      bad++; $display("FAIL reset_fwd_sel got=%0h exp=0", src_fwd_sel);
    end
    total++;
    if (stall_count !== 32'd0) begin
      bad++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count);
    end
    step();
    total++;
    if (src_fwd_sel !== 4'b0000) begin
      bad++; $display("FAIL reset_fwd_sel_held got=%0h exp=0", src_fwd_sel);
    end
    reset_n = 1;
    #1;
    total++;
    if (src_fwd_sel !== 4'b0001) begin
      bad++; $display("FAIL reset_release_fwd got=%0h exp=1", src_fwd_sel);
    end
  endtask

  // Latency-2 RAW hazard; an issue offered during the stall is dropped.
  task automatic test_raw_latency();
    apply_reset();
    issue_valid = 1; issue_dest = 5'd5; issue_latency = 4'd2;
    step();
    issue_dest = 5'd6; issue_latency = 4'd3;
    src_reg = {5'd0, 5'd5};
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_c1 got=%0b exp=1", stall); end
    step();
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_c2 got=%0b exp=1", stall); end
    total++;
    if (stall_count !== 32'd1) begin
      bad++; $display("FAIL raw_count_c2 got=%0d exp=1", stall_count);
    end
    step();
    issue_valid = 0;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL raw_stall_c3 got=%0b exp=0", stall); end
    total++;
    if (stall_count !== 32'd2) begin
      bad++; $display("FAIL raw_count_final got=%0d exp=2", stall_count);
    end
    src_reg = {5'd0, 5'd6};
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL raw_dropped_issue got=%0b exp=0", stall);
    end
    step();
    total++;
    if (stall_count !== 32'd2) begin
      bad++; $display("FAIL raw_count_hold got=%0d exp=2", stall_count);
    end
  endtask

  // Forward priority across stages.
  task automatic test_forward();
    apply_reset();
    stage_wr = 3'b011;
    stage_dest = {5'd9, 5'd7, 5'd7};
    src_reg = {5'd7, 5'd9};
    #1;
    total++;
    if (src_fwd_sel !== 4'b0100) begin
      bad++; $display("FAIL fwd_youngest got=%0h exp=4", src_fwd_sel);
    end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL fwd_no_stall got=%0b exp=0", stall); end
    stage_wr = 3'b110;
    #1;
    total++;
    if (src_fwd_sel !== 4'b1011) begin
      bad++; $display("FAIL fwd_stage2_3 got=%0h exp=b", src_fwd_sel);
    end
    stage_wr = 3'b000;
    #1;
    total++;
    if (src_fwd_sel !== 4'b0000) begin
      bad++; $display("FAIL fwd_none got=%0h exp=0", src_fwd_sel);
    end
  endtask

  // Register 0 is never tracked nor forwarded.
  task automatic test_zero_reg();
    apply_reset();
    issue_valid = 1; issue_dest = 5'd0; issue_latency = 4'd5;
    step();
    issue_valid = 0;
    src_reg = 10'd0;
    stage_wr = 3'b111;
    stage_dest = 15'd0;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%0b exp=0", stall); end
    total++;
    if (src_fwd_sel !== 4'b0000) begin
      bad++; $display("FAIL zero_fwd got=%0h exp=0", src_fwd_sel);
    end
    step();
    total++;
    if (stall_count !== 32'd0) begin
      bad++; $display("FAIL zero_count got=%0d exp=0", stall_count);
    end
  endtask

  // Flush clears a live counter and drops a same-cycle issue.
  task automatic test_flush();
    apply_reset();
    issue_valid = 1; issue_dest = 5'd9; issue_latency = 4'd3;
    step();
    issue_valid = 0;
    src_reg = {5'd0, 5'd9};
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0b exp=1", stall); end
    src_reg = 10'd0;
    flush = 1; issue_valid = 1; issue_dest = 5'd9; issue_latency = 4'd5;
    step();
    flush = 0; issue_valid = 0;
    src_reg = {5'd0, 5'd9};
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_post got=%0b exp=0", stall); end
    step();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_post2 got=%0b exp=0", stall); end
    total++;
    if (stall_count !== 32'd0) begin
      bad++; $display("FAIL flush_count got=%0d exp=0", stall_count);
    end
  endtask

  // WAW: a shorter second write keeps the longer remaining latency.
  task automatic test_waw();
    apply_reset();
    issue_valid = 1; issue_dest = 5'd4; issue_latency = 4'd5;
    step();
    issue_latency = 4'd1;
    step();
    issue_valid = 0;
    src_reg = {5'd4, 5'd0};
    #1;
    for (int n = 0; n < 4; n++) begin
      total++;
      if (stall !== 1'b1) begin
        bad++; $display("FAIL waw_stall_%0d got=%0b exp=1", n, stall);
      end
      step();
    end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL waw_release got=%0b exp=0", stall); end
    total++;
    if (stall_count !== 32'd4) begin
      bad++; $display("FAIL waw_count got=%0d exp=4", stall_count);
    end
  endtask

  // Asynchronous reset in the middle of a stall.
  task automatic test_async_reset();
    apply_reset();
    issue_valid = 1; issue_dest = 5'd3; issue_latency = 4'd6;
    step();
    issue_valid = 0;
    src_reg = {5'd0, 5'd3};
    stage_wr = 3'b001;
    stage_dest = {5'd0, 5'd0, 5'd3};
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL areset_pre got=%0b exp=1", stall); end
    total++;
    if (src_fwd_sel !== 4'b0001) begin
      bad++; $display("FAIL areset_pre_fwd got=%0h exp=1", src_fwd_sel);
    end
    step();
    step();
    total++;
    if (stall_count !== 32'd2) begin
      bad++; $display("FAIL areset_pre_count got=%0d exp=2", stall_count);
    end
    #3;
    reset_n = 0;
    issue_valid = 1; issue_dest = 5'd8; issue_latency = 4'd4;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL areset_stall got=%0b exp=0", stall); end
    total++;
    if (stall_count !== 32'd0) begin
      bad++; $display("FAIL areset_count got=%0d exp=0", stall_count);
    end
    total++;
    if (src_fwd_sel !== 4'b0000) begin
      bad++; $display("FAIL areset_fwd got=%0h exp=0", src_fwd_sel);
    end
    step();
    reset_n = 1;
    issue_valid = 0;
    stage_wr = 3'b000;
    src_reg = {5'd3, 5'd8};
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL areset_no_issue got=%0b exp=0", stall);
    end
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_raw_latency();
    test_forward();
    test_zero_reg();
    test_flush();
    test_waw();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
